// File: rtl/argmax_pkg.sv
// Shared types and defaults for the streaming argmax unit.
package argmax_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } argmax_state_t;

  localparam int ARGMAX_WIDTH_DEF = 4;
  localparam int ARGMAX_N_DEF     = 8;

  // A single-sample frame still needs a one-bit index port.
  function automatic int argmax_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/argmax_max_sel.sv
// Keep-or-replace decision for the running maximum: comparator plus 2:1 select of {value, index}.
// Build option ARGMAX_SIGNED_EN switches the comparison to two's-complement.
module max_sel #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] cur_max,
  input  logic [IDX_W-1:0] cur_idx,
  input  logic [WIDTH-1:0] cand_val,
  input  logic [IDX_W-1:0] cand_idx,
  input  logic             force_load,
  output logic [WIDTH-1:0] sel_max,
  output logic [IDX_W-1:0] sel_idx
);

  logic greater;

`ifdef ARGMAX_SIGNED_EN
  assign greater = $signed(cand_val) > $signed(cur_max);
`else
  assign greater = cand_val > cur_max;
`endif

  // Strict compare: ties keep the earlier (lower) index.
  always_comb begin
    sel_max = cur_max;
    sel_idx = cur_idx;
    if (force_load || greater) begin
      sel_max = cand_val;
      sel_idx = cand_idx;
    end
  end

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax: collects N samples per frame, presents {max, index} until the consumer takes it.
// Build option ARGMAX_SIGNED_EN selects signed comparison (see max_sel).
//
// state | meaning
// ACC   | collecting samples, in_ready high
// HOLD  | result presented, waiting for out_ready
module argmax_stream
  import argmax_pkg::*;
#(
  parameter int WIDTH = ARGMAX_WIDTH_DEF,
  parameter int N     = ARGMAX_N_DEF,
  localparam int IDX_W = argmax_idx_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx
);

  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] CNT_ONE  = IDX_W'(1);

  argmax_state_t    state;
  logic [IDX_W-1:0] cnt;
  logic [WIDTH-1:0] max_r;
  logic [IDX_W-1:0] idx_r;
  logic [WIDTH-1:0] sel_max;
  logic [IDX_W-1:0] sel_idx;
  logic             accept;
  logic             first;
  logic             last;

  // Gated with rst_n so nothing is offered to the source during reset.
  assign in_ready = (state == ACC) && rst_n;
  assign accept   = in_valid && in_ready;
  assign first    = (cnt == '0);
  assign last     = (cnt == CNT_LAST);

  max_sel #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_max_sel (
    .cur_max    (max_r),
    .cur_idx    (idx_r),
    .cand_val   (in_data),
    .cand_idx   (cnt),
    .force_load (first),
    .sel_max    (sel_max),
    .sel_idx    (sel_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      cnt       <= '0;
      max_r     <= '0;
      idx_r     <= '0;
      out_valid <= 1'b0;
      out_max   <= '0;
      out_idx   <= '0;
    end else if (clear) begin
      // Abort the frame; the last delivered result stays on out_max/out_idx.
      state     <= ACC;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            max_r <= sel_max;
            idx_r <= sel_idx;
            if (last) begin
              state     <= HOLD;
              cnt       <= '0;
              out_max   <= sel_max;
              out_idx   <= sel_idx;
              out_valid <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACC;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_stream.sv
// Scoreboard bench for argmax_stream: an N=4 instance for the frame tests and an N=1 instance for single-sample frames.
module tb_argmax_stream;

  logic       clk;
  logic       rst_n;
  logic       clear;

  logic       in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0] in_data4, out_max4;
  logic [1:0] out_idx4;

  logic       in_valid1, in_ready1, out_valid1, out_ready1;
  logic [3:0] in_data1, out_max1;
  logic [0:0] out_idx1;

  int n_cmp  = 0;
  int n_fail = 0;

  int q4_max[$];
  int q4_idx[$];
  int q1_max[$];
  int q1_idx[$];

  argmax_stream #(.WIDTH(4), .N(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_data   (in_data4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_max   (out_max4),
    .out_idx   (out_idx4)
  );

  argmax_stream #(.WIDTH(4), .N(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_data   (in_data1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_max   (out_max1),
    .out_idx   (out_idx1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop the expected result whenever a result handshake is pending.
  always @(negedge clk) begin
    if (rst_n && out_valid4 && out_ready4) begin
      if (q4_max.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL dut4_unexpected: got result max=%0d idx=%0d expected none", out_max4, out_idx4);
      end else begin
        chk("dut4_max", int'(out_max4), q4_max.pop_front());
        chk("dut4_idx", int'(out_idx4), q4_idx.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid1 && out_ready1) begin
      if (q1_max.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL dut1_unexpected: got result max=%0d idx=%0d expected none", out_max1, out_idx1);
      end else begin
        chk("dut1_max", int'(out_max1), q1_max.pop_front());
        chk("dut1_idx", int'(out_idx1), q1_idx.pop_front());
      end
    end
  end

  // All send tasks start and end at posedge+1.
  task automatic send4(input logic [3:0] d);
    int t;
    in_valid4 = 1'b1;
    in_data4  = d;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready4) break;
      t++;
      if (t > 50) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send4_timeout: got in_ready=0 expected 1 within 50 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    in_data4  = 'x;
  endtask

  task automatic send1(input logic [3:0] d);
    int t;
    in_valid1 = 1'b1;
    in_data1  = d;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready1) break;
      t++;
      if (t > 50) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send1_timeout: got in_ready=0 expected 1 within 50 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    in_data1  = 'x;
  endtask

  task automatic expect4(input int m, input int i);
    q4_max.push_back(m);
    q4_idx.push_back(i);
  endtask

  typedef logic [3:0] nib_t;

  initial begin
    nib_t s;
    int   gap;
    int   t;

    rst_n      = 1'b0;
    clear      = 1'b0;
    in_valid4  = 1'b0;
    in_data4   = 'x;
    out_ready4 = 1'b1;
    in_valid1  = 1'b0;
    in_data1   = 'x;
    out_ready1 = 1'b1;

    #2;
    chk("reset_out_valid", int'(out_valid4), 0);
    chk("reset_out_max", int'(out_max4), 0);
    chk("reset_out_idx", int'(out_idx4), 0);
    chk("reset_in_ready", int'(in_ready4), 0);
    chk("reset_in_ready_n1", int'(in_ready1), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", int'(in_ready4), 1);
    @(posedge clk);
    #1;

    // Back-to-back frame, tie keeps first index; in_ready low for one cycle.
    expect4(9, 1);
    send4(4'd3); send4(4'd9); send4(4'd2); send4(4'd9);
    @(negedge clk);
    chk("hold_in_ready", int'(in_ready4), 0);
    chk("hold_out_valid", int'(out_valid4), 1);
    @(negedge clk);
    chk("release_in_ready", int'(in_ready4), 1);
    chk("release_out_valid", int'(out_valid4), 0);
    @(posedge clk);
    #1;

    // Backpressure: result must stay put for 5 cycles.
    out_ready4 = 1'b0;
    expect4(9, 1);
    send4(4'd3); send4(4'd9); send4(4'd2); send4(4'd9);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid4), 1);
      chk("bp_out_max", int'(out_max4), 9);
      chk("bp_out_idx", int'(out_idx4), 1);
      chk("bp_in_ready", int'(in_ready4), 0);
    end
    @(posedge clk);
    #1;
    out_ready4 = 1'b1;
    expect4(8, 0);
    send4(4'd8); send4(4'd1); send4(4'd1); send4(4'd1);

    // Clear mid-frame discards partial frame and the concurrent sample.
    expect4(4, 3);
    send4(4'd5); send4(4'd7);
    clear     = 1'b1;
    in_valid4 = 1'b1;
    in_data4  = 4'd15;
    @(posedge clk);
    #1;
    clear     = 1'b0;
    in_valid4 = 1'b0;
    in_data4  = 'x;
    send4(4'd1); send4(4'd2); send4(4'd3); send4(4'd4);

    // Reset mid-frame.
    send4(4'd10); send4(4'd11);
    chk("pre_reset_out_max", int'(out_max4), 4);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_out_valid", int'(out_valid4), 0);
    chk("mid_reset_out_max", int'(out_max4), 0);
    chk("mid_reset_out_idx", int'(out_idx4), 0);
    chk("mid_reset_in_ready", int'(in_ready4), 0);
    @(negedge clk);
    chk("mid_reset_in_ready_held", int'(in_ready4), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect4(6, 0);
    send4(4'd6); send4(4'd1); send4(4'd1); send4(4'd1);

    // Signedness-dependent frame.
`ifdef ARGMAX_SIGNED_EN
    expect4(2, 1);
`else
    expect4(15, 0);
`endif
    send4(4'hF); send4(4'h2); send4(4'h8); send4(4'h1);

    // N=1 with random gaps.
    for (int k = 0; k < 10; k++) begin
      s = nib_t'((k * 7 + 3) % 16);
      q1_max.push_back(int'(s));
      q1_idx.push_back(0);
      send1(s);
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end

    t = 0;
    while ((q4_max.size() != 0 || q1_max.size() != 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    chk("dut4_pending", q4_max.size(), 0);
    chk("dut1_pending", q1_max.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
